// File: rtl/instruction_mem_if.sv
// Operand/opcode inputs and registered results of the execute stage, bundled as one port.
// The master drives operands and opcode; the slave returns the registered results.
interface instruction_mem_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OPW-1:0]   opcode;
  logic [OPW-1:0]   alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             carry_out;
  logic [WIDTH-1:0] data_out;

  modport master (
    output a, b, opcode,
    input  alu_sel, alu_out, carry_out, data_out
  );

  modport slave (
    input  a, b, opcode,
    output alu_sel, alu_out, carry_out, data_out
  );
endinterface

// File: rtl/instruction_mem.sv
// Execute stage: combinational ALU, registered result/flag/select, and a per-opcode
// result store whose read-first output shows the previous result for the same opcode.
module instruction_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OPW   = 3
) (
  input logic               clk,
  input logic               reset,
  instruction_mem_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << OPW;

  localparam logic [OPW-1:0] OpAdd = 3'd0;
  localparam logic [OPW-1:0] OpSub = 3'd1;
  localparam logic [OPW-1:0] OpAnd = 3'd2;
  localparam logic [OPW-1:0] OpOr  = 3'd3;
  localparam logic [OPW-1:0] OpXor = 3'd4;
  localparam logic [OPW-1:0] OpMul = 3'd5;
  localparam logic [OPW-1:0] OpDiv = 3'd6;
  localparam logic [OPW-1:0] OpCmp = 3'd7;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res;
  logic               flag;
  logic [WIDTH-1:0]   mem_q [DEPTH];

  always_comb begin
    sum  = {1'b0, bus.a} + {1'b0, bus.b};
    prod = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    res  = '0;
    flag = 1'b0;
    unique case (bus.opcode)
      OpAdd: begin
        res  = sum[WIDTH-1:0];
        flag = sum[WIDTH];
      end
      OpSub: begin
        res  = bus.a - bus.b;
        flag = (bus.a < bus.b);
      end
      OpAnd: res = bus.a & bus.b;
      OpOr:  res = bus.a | bus.b;
      OpXor: res = bus.a ^ bus.b;
      OpMul: begin
        res  = prod[WIDTH-1:0];
        flag = |prod[2*WIDTH-1:WIDTH];
      end
      OpDiv: begin
        // Divide by zero saturates the result and raises the flag.
        if (bus.b == '0) begin
          res  = '1;
          flag = 1'b1;
        end else begin
          res  = bus.a / bus.b;
        end
      end
      OpCmp: res = {{(WIDTH-3){1'b0}}, (bus.a > bus.b), (bus.a == bus.b), (bus.a < bus.b)};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.alu_sel   <= '0;
      bus.alu_out   <= '0;
      bus.carry_out <= 1'b0;
      bus.data_out  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      bus.alu_sel          <= bus.opcode;
      bus.alu_out          <= res;
      bus.carry_out        <= flag;
      // Read-first: the store entry is sampled before this edge's write lands.
      bus.data_out         <= mem_q[bus.opcode];
      mem_q[bus.opcode]    <= res;
    end
  end

endmodule

// File: tb/tb_instruction_mem.sv
// Randomized scoreboard bench for instruction_mem: a driver queues expected results from an
// arithmetic reference model, and a monitor pops and compares one entry per active edge.
module tb_instruction_mem;

  logic clk;
  logic reset;

  instruction_mem_if #(.WIDTH(8), .OPW(3)) bus ();

  instruction_mem #(.WIDTH(8), .OPW(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] out;
    logic       c;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_mem [8];
  int         total = 0;
  int         bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference computed directly from the opcode table with integer arithmetic.
  task automatic ref_op(input logic [2:0] op, input int x, input int y,
                        output logic [7:0] r, output logic c);
    int v;
    v = 0;
    c = 1'b0;
    case (op)
      3'd0: begin v = x + y;               c = (v > 255); end
      3'd1: begin v = (x - y + 256) % 256; c = (x < y);   end
      3'd2: v = x & y;
      3'd3: v = x | y;
      3'd4: v = x ^ y;
      3'd5: begin v = x * y;               c = (v >= 256); end
      3'd6: begin
        if (y == 0) begin v = 255; c = 1'b1; end
        else v = x / y;
      end
      default: v = ((x > y) ? 4 : 0) + ((x == y) ? 2 : 0) + ((x < y) ? 1 : 0);
    endcase
    r = 8'(v % 256);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) model_mem[i] = 8'd0;
  endtask

  // Drives one operation and queues its expected response; optionally waits for a negedge.
  task automatic issue(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                       input bit wait_edge);
    exp_t       e;
    logic [7:0] r;
    logic       c;
    if (wait_edge) @(negedge clk);
    bus.opcode = op;
    bus.a      = x;
    bus.b      = y;
    ref_op(op, int'(x), int'(y), r, c);
    e.sel  = op;
    e.out  = r;
    e.c    = c;
    e.data = model_mem[op];
    model_mem[op] = r;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_alu_sel"},   int'(bus.alu_sel),   0);
    check({tag, "_alu_out"},   int'(bus.alu_out),   0);
    check({tag, "_carry_out"}, int'(bus.carry_out), 0);
    check({tag, "_data_out"},  int'(bus.data_out),  0);
  endtask

  always @(posedge clk) begin
    #1;
    if (reset && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("alu_sel",   int'(bus.alu_sel),   int'(e.sel));
      check("alu_out",   int'(bus.alu_out),   int'(e.out));
      check("carry_out", int'(bus.carry_out), int'(e.c));
      check("data_out",  int'(bus.data_out),  int'(e.data));
    end
  end

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    int         waited;
    reset      = 1'b0;
    bus.a      = 8'd0;
    bus.b      = 8'd0;
    bus.opcode = 3'd0;
    clear_model();

    @(negedge clk);
    check_zero("reset_c1");
    @(negedge clk);
    check_zero("reset_c2");
    reset = 1'b1;

    // One of each opcode with a=5, b=3: first use of every store entry.
    issue(3'd0, 8'd5, 8'd3, 1'b0);
    for (int op = 1; op < 8; op++) issue(3'(op), 8'd5, 8'd3, 1'b1);

    // Same opcode twice in a row: the second read returns the first result.
    issue(3'd0, 8'd5, 8'd3, 1'b1);
    issue(3'd0, 8'd5, 8'd3, 1'b1);

    // Boundary operands.
    issue(3'd0, 8'd255, 8'd1,  1'b1);
    issue(3'd1, 8'd3,   8'd5,  1'b1);
    issue(3'd5, 8'd16,  8'd16, 1'b1);
    issue(3'd6, 8'd7,   8'd0,  1'b1);
    issue(3'd7, 8'd9,   8'd9,  1'b1);
    issue(3'd6, 8'd0,   8'd0,  1'b1);
    issue(3'd5, 8'd255, 8'd255, 1'b1);

    // Reset asserted between edges with an operation in flight: it must be dropped.
    issue(3'd2, 8'hF0, 8'h3C, 1'b1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    clear_model();
    #1;
    check_zero("async_reset");
    @(negedge clk);
    check_zero("reset_hold");
    reset = 1'b1;
    issue(3'd0, 8'd5, 8'd3, 1'b0);

    // Random stream with occasional edge-case operands.
    for (int n = 0; n < 1200; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 7))
        0: rb = 8'd0;
        1: ra = 8'd255;
        2: rb = ra;
        default: ;
      endcase
      issue(3'($urandom_range(0, 7)), ra, rb, 1'b1);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("drain_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
